// File: rtl/sha_compress_pkg.sv
// Shared SHA-256 definitions: word width, round functions, K constant table, FSM states.
// Used by sha_compress and sha_round.
package sha_compress_pkg;

    localparam int W_MAX          = 32;
    localparam int ROUNDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } sha_state_t;

    localparam logic [W_MAX-1:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [W_MAX-1:0] k_const(input logic [5:0] t);
        return K_TABLE[t];
    endfunction

    function automatic logic [W_MAX-1:0] big_sigma0(input logic [W_MAX-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [W_MAX-1:0] big_sigma1(input logic [W_MAX-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    // Schedule functions, kept here so the expansion stage shares one definition.
    function automatic logic [W_MAX-1:0] small_sigma0(input logic [W_MAX-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [W_MAX-1:0] small_sigma1(input logic [W_MAX-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [W_MAX-1:0] sha_ch(input logic [W_MAX-1:0] x,
                                                input logic [W_MAX-1:0] y,
                                                input logic [W_MAX-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [W_MAX-1:0] sha_maj(input logic [W_MAX-1:0] x,
                                                 input logic [W_MAX-1:0] y,
                                                 input logic [W_MAX-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 round: working state a..h (a in the top word) plus K[t], W[t]
// in, next working state out.
module sha_round
    import sha_compress_pkg::*;
(
    input  logic [255:0]      i_state,
    input  logic [W_MAX-1:0]  i_k,
    input  logic [W_MAX-1:0]  i_w,
    output logic [255:0]      o_state
);

    logic [W_MAX-1:0] w_v [0:7];
    logic [W_MAX-1:0] w_t1;
    logic [W_MAX-1:0] w_t2;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            assign w_v[gi] = i_state[255-32*gi -: 32];
        end
    endgenerate

    assign w_t1 = w_v[7] + big_sigma1(w_v[4]) + sha_ch(w_v[4], w_v[5], w_v[6]) + i_k + i_w;
    assign w_t2 = big_sigma0(w_v[0]) + sha_maj(w_v[0], w_v[1], w_v[2]);

    assign o_state = {w_t1 + w_t2, w_v[0], w_v[1], w_v[2],
                      w_v[3] + w_t1, w_v[4], w_v[5], w_v[6]};

endmodule

// File: rtl/sha_compress.sv
// Iterative SHA-256 compression, one round per clock, en/en_next pulse handshake.
// Optional macro SHA_FEEDFORWARD_EN adds the chaining value into the output; otherwise raw a..h.
module sha_compress
    import sha_compress_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2047:0] W,
    input  logic [255:0]  H_in,
    output logic [255:0]  H_out,
    output logic          en_next,
    output logic          busy
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    sha_state_t     r_state;
    sha_state_t     w_state_next;
    logic [2047:0]  r_w;
    logic [255:0]   r_work;
    logic [5:0]     r_t;
    logic [255:0]   r_h_out;
    logic           r_en_next;
    logic [255:0]   w_round_next;
    logic [255:0]   w_result;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_state_next = ST_ROUND;
            ST_ROUND: if (r_t == LAST_ROUND) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    sha_round u_round (
        .i_state (r_work),
        .i_k     (k_const(r_t)),
        .i_w     (r_w[{r_t, 5'd0} +: 32]),
        .o_state (w_round_next)
    );

`ifdef SHA_FEEDFORWARD_EN
    logic [255:0] r_h_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_in <= '0;
        end else if (r_state == ST_IDLE && en) begin
            r_h_in <= H_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ff
            assign w_result[32*gi +: 32] = r_work[32*gi +: 32] + r_h_in[32*gi +: 32];
        end
    endgenerate
`else
    // Midstate path: the chaining-value adds happen downstream.
    assign w_result = r_work;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_w       <= '0;
            r_work    <= '0;
            r_t       <= '0;
            r_h_out   <= '0;
            r_en_next <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_en_next <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_w    <= W;
                        r_work <= H_in;
                        r_t    <= '0;
                    end
                end
                ST_ROUND: begin
                    r_work <= w_round_next;
                    r_t    <= r_t + 6'd1;
                end
                ST_DONE: begin
                    r_h_out   <= w_result;
                    r_en_next <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign H_out   = r_h_out;
    assign en_next = r_en_next;
    assign busy    = (r_state != ST_IDLE);

endmodule
